// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, functs,
// ALU operations, FSM states, datapath mux selects and the control word.
package ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FN_W    = 6;
    localparam int unsigned ALUOP_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0a;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0c;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0e;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

    localparam logic [FN_W-1:0] FN_SRL  = 6'h02;
    localparam logic [FN_W-1:0] FN_JR   = 6'h08;
    localparam logic [FN_W-1:0] FN_JALR = 6'h09;
    localparam logic [FN_W-1:0] FN_ADD  = 6'h20;
    localparam logic [FN_W-1:0] FN_SUB  = 6'h22;
    localparam logic [FN_W-1:0] FN_AND  = 6'h24;
    localparam logic [FN_W-1:0] FN_OR   = 6'h25;
    localparam logic [FN_W-1:0] FN_XOR  = 6'h26;
    localparam logic [FN_W-1:0] FN_SLT  = 6'h2a;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_XOR = 3'b011,
        ALU_SRL = 3'b101,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [3:0] {
        ST_RESET, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_READ, ST_MEM_WB,
        ST_MEM_WRITE, ST_EXEC_R, ST_EXEC_I, ST_ALU_WB, ST_BRANCH, ST_JUMP,
        ST_JAL, ST_JR
    } state_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_REGA   = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        SRCB_B      = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_srcb_e;

    // Which ALU function a state needs: fixed add/sub or decoded from IR
    typedef enum logic [1:0] {
        CLS_ADD, CLS_SUB, CLS_RTYPE, CLS_ITYPE
    } alu_cls_e;

    typedef struct packed {
        logic      pc_write;
        logic      pc_write_cond;
        logic      bne;
        pc_src_e   pc_source;
        logic      iord;
        logic      mem_read;
        logic      mem_write;
        logic      ir_write;
        logic      alu_src_a;
        alu_srcb_e alu_src_b;
        alu_op_e   alu_op;
        logic      reg_dst;
        logic      mem_to_reg;
        logic      reg_write;
        logic      jal;
        logic      lui;
        logic      zero_ext;
        logic      instr_done;
        logic      illegal_op;
    } ctrl_t;

endpackage

// File: rtl/multi_cycle_control_if.sv
// Controller <-> datapath bundle: IR fields and memory handshake in, control strobes out.
interface multi_cycle_control_if;
    import ctrl_pkg::*;

    logic [OP_W-1:0]    opcode;
    logic [FN_W-1:0]    funct;
    logic               mem_ready;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               BNE;
    logic [1:0]         PCSource;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [ALUOP_W-1:0] ALUop;
    logic               RegDst;
    logic               MemtoReg;
    logic               RegWrite;
    logic               Jal;
    logic               LUI;
    logic               signal;
    logic               instr_done;
    logic               illegal_op;

    modport master (
        input  opcode, funct, mem_ready,
        output PCWrite, PCWriteCond, BNE, PCSource, IorD, MemRead, MemWrite,
               IRWrite, ALUSrcA, ALUSrcB, ALUop, RegDst, MemtoReg, RegWrite,
               Jal, LUI, signal, instr_done, illegal_op
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  PCWrite, PCWriteCond, BNE, PCSource, IorD, MemRead, MemWrite,
               IRWrite, ALUSrcA, ALUSrcB, ALUop, RegDst, MemtoReg, RegWrite,
               Jal, LUI, signal, instr_done, illegal_op
    );

endinterface

// File: rtl/alu_op_decode.sv
// ALU operation and instruction-legality decode for the multi-cycle controller.
// Maps the state's ALU class plus IR opcode/funct to an ALUop.
module alu_op_decode
    import ctrl_pkg::*;
(
    input  alu_cls_e        cls,
    input  logic [OP_W-1:0] opcode,
    input  logic [FN_W-1:0] funct,
    output alu_op_e         aluop,
    output logic            illegal
);

    alu_op_e r_op;
    alu_op_e i_op;
    logic    r_ok;
    logic    i_ok;
    logic    legal;

    // R-type funct table; jr/jalr are legal but are dispatched away from EXEC_R
    always_comb begin
        r_op = ALU_ADD;
        r_ok = 1'b1;
        case (funct)
            FN_ADD:          r_op = ALU_ADD;
            FN_SUB:          r_op = ALU_SUB;
            FN_AND:          r_op = ALU_AND;
            FN_OR:           r_op = ALU_OR;
            FN_XOR:          r_op = ALU_XOR;
            FN_SLT:          r_op = ALU_SLT;
            FN_SRL:          r_op = ALU_SRL;
            FN_JR, FN_JALR:  r_op = ALU_ADD;
            default:         r_ok = 1'b0;
        endcase
    end

    // lui adds; the datapath's LUI mux places the immediate in the upper half
    always_comb begin
        i_op = ALU_ADD;
        i_ok = 1'b1;
        case (opcode)
            OP_ADDI: i_op = ALU_ADD;
            OP_SLTI: i_op = ALU_SLT;
            OP_ANDI: i_op = ALU_AND;
            OP_ORI:  i_op = ALU_OR;
            OP_XORI: i_op = ALU_XOR;
            OP_LUI:  i_op = ALU_ADD;
            default: i_ok = 1'b0;
        endcase
    end

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE:                                   legal = r_ok;
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: legal = 1'b1;
            default:                                    legal = i_ok;
        endcase
    end

    always_comb begin
        aluop = ALU_ADD;
        case (cls)
            CLS_SUB:   aluop = ALU_SUB;
            CLS_RTYPE: aluop = r_op;
            CLS_ITYPE: aluop = i_op;
            default:   aluop = ALU_ADD;
        endcase
    end

    assign illegal = !legal;

endmodule

// File: rtl/multi_cycle_control.sv
// Moore sequencer stepping the shared MIPS-subset datapath through fetch/decode/execute.
// Define MC_CTRL_MEM_WAIT_EN to stall FETCH, MEM_READ and MEM_WRITE on mem_ready.
module multi_cycle_control
    import ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    multi_cycle_control_if.master bus
);

    state_e   state;
    state_e   state_nxt;
    logic     wb_rtype;
    logic     wb_rtype_nxt;
    ctrl_t    ctl;
    alu_cls_e cls;
    alu_op_e  aluop;
    logic     illegal;
    logic     mem_go;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_go = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign mem_go = 1'b1;
`endif

    always_comb begin
        cls = CLS_ADD;
        case (state)
            ST_EXEC_R: cls = CLS_RTYPE;
            ST_EXEC_I: cls = CLS_ITYPE;
            ST_BRANCH: cls = CLS_SUB;
            default:   cls = CLS_ADD;
        endcase
    end

    alu_op_decode u_alu_op_decode (
        .cls     (cls),
        .opcode  (bus.opcode),
        .funct   (bus.funct),
        .aluop   (aluop),
        .illegal (illegal)
    );

    // wb_rtype remembers which execute state fed ALU_WB, since IR is not decoded there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RESET;
            wb_rtype <= 1'b0;
        end else begin
            state    <= state_nxt;
            wb_rtype <= wb_rtype_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wb_rtype_nxt = wb_rtype;
        ctl          = '0;
        case (state)
            ST_RESET: state_nxt = ST_FETCH;
            ST_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.ir_write  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = aluop;
                ctl.pc_source = PCSRC_ALU;
                ctl.pc_write  = mem_go;
                if (mem_go) state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                ctl.alu_src_b = SRCB_IMM_SH2;
                ctl.alu_op    = aluop;
                if (illegal) begin
                    ctl.illegal_op = 1'b1;
                    state_nxt      = ST_FETCH;
                end else begin
                    case (bus.opcode)
                        OP_LW, OP_SW:     state_nxt = ST_MEM_ADDR;
                        OP_RTYPE:         state_nxt = (bus.funct == FN_JR || bus.funct == FN_JALR)
                                                      ? ST_JR : ST_EXEC_R;
                        OP_BEQ, OP_BNE:   state_nxt = ST_BRANCH;
                        OP_J:             state_nxt = ST_JUMP;
                        OP_JAL:           state_nxt = ST_JAL;
                        default:          state_nxt = ST_EXEC_I;
                    endcase
                end
            end
            ST_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = aluop;
                state_nxt     = (bus.opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            end
            ST_MEM_READ: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
                if (mem_go) state_nxt = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.instr_done = 1'b1;
                state_nxt      = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                ctl.mem_write  = 1'b1;
                ctl.iord       = 1'b1;
                ctl.instr_done = mem_go;
                if (mem_go) state_nxt = ST_FETCH;
            end
            ST_EXEC_R: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_op    = aluop;
                wb_rtype_nxt  = 1'b1;
                state_nxt     = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = aluop;
                ctl.lui       = (bus.opcode == OP_LUI);
                ctl.zero_ext  = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI) ||
                                (bus.opcode == OP_XORI);
                wb_rtype_nxt  = 1'b0;
                state_nxt     = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = wb_rtype;
                ctl.instr_done = 1'b1;
                state_nxt      = ST_FETCH;
            end
            ST_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = SRCB_B;
                ctl.alu_op        = aluop;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCSRC_ALUOUT;
                ctl.bne           = (bus.opcode == OP_BNE);
                ctl.instr_done    = 1'b1;
                state_nxt         = ST_FETCH;
            end
            ST_JUMP: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_source  = PCSRC_JUMP;
                ctl.instr_done = 1'b1;
                state_nxt      = ST_FETCH;
            end
            ST_JAL: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_source  = PCSRC_JUMP;
                ctl.reg_write  = 1'b1;
                ctl.jal        = 1'b1;
                ctl.instr_done = 1'b1;
                state_nxt      = ST_FETCH;
            end
            ST_JR: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_source  = PCSRC_REGA;
                ctl.instr_done = 1'b1;
                if (bus.funct == FN_JALR) begin
                    ctl.reg_write = 1'b1;
                    ctl.jal       = 1'b1;
                    ctl.reg_dst   = 1'b1;
                end
                state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_RESET;
        endcase
    end

    assign bus.PCWrite     = ctl.pc_write;
    assign bus.PCWriteCond = ctl.pc_write_cond;
    assign bus.BNE         = ctl.bne;
    assign bus.PCSource    = ctl.pc_source;
    assign bus.IorD        = ctl.iord;
    assign bus.MemRead     = ctl.mem_read;
    assign bus.MemWrite    = ctl.mem_write;
    assign bus.IRWrite     = ctl.ir_write;
    assign bus.ALUSrcA     = ctl.alu_src_a;
    assign bus.ALUSrcB     = ctl.alu_src_b;
    assign bus.ALUop       = ctl.alu_op;
    assign bus.RegDst      = ctl.reg_dst;
    assign bus.MemtoReg    = ctl.mem_to_reg;
    assign bus.RegWrite    = ctl.reg_write;
    assign bus.Jal         = ctl.jal;
    assign bus.LUI         = ctl.lui;
    assign bus.signal      = ctl.zero_ext;
    assign bus.instr_done  = ctl.instr_done;
    assign bus.illegal_op  = ctl.illegal_op;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: directed and random instruction streams, each expanded
// into its expected per-cycle control words and checked through a scoreboard queue.
module tb_multi_cycle_control;

`ifdef MC_CTRL_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pcw, pcwc, bne;
        logic [1:0] pcsrc;
        logic       iord, mrd, mwr, irw, srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic       regdst, m2r, regw, jal, lui, sig, done, ill;
    } word_t;

    logic  clk = 1'b0;
    logic  rst_n;
    bit    done = 1'b0;
    int    checks = 0;
    int    failures = 0;
    word_t exp_q[$];
    string tag_q[$];
    word_t seq_w[$];
    bit    seq_mr[$];
    string seq_t[$];
    string cur_name;
    word_t mon_exp;
    string mon_tag;

    logic [5:0] ops [0:12] = '{6'h23, 6'h2b, 6'h00, 6'h08, 6'h0a, 6'h0c, 6'h0d,
                               6'h0e, 6'h0f, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] fns [0:8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2a, 6'h02,
                               6'h08, 6'h09};

    multi_cycle_control_if bus ();

    multi_cycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic word_t sample();
        word_t w;
        w.pcw = bus.PCWrite;   w.pcwc = bus.PCWriteCond; w.bne = bus.BNE;
        w.pcsrc = bus.PCSource; w.iord = bus.IorD;       w.mrd = bus.MemRead;
        w.mwr = bus.MemWrite;  w.irw = bus.IRWrite;      w.srca = bus.ALUSrcA;
        w.srcb = bus.ALUSrcB;  w.aluop = bus.ALUop;      w.regdst = bus.RegDst;
        w.m2r = bus.MemtoReg;  w.regw = bus.RegWrite;    w.jal = bus.Jal;
        w.lui = bus.LUI;       w.sig = bus.signal;       w.done = bus.instr_done;
        w.ill = bus.illegal_op;
        return w;
    endfunction

    task automatic check(string name, word_t act, word_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (diff %h) t=%0t", name, act, exp, act ^ exp, $time);
        end
    endtask

    // Monitor: every falling edge either checks the reset-forced zero word or pops one expectation
    always @(negedge clk) begin
        if (!done) begin
            if (!rst_n) begin
                check("in_reset", sample(), '0);
            end else if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: got %h expected no activity", sample());
            end else begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                check(mon_tag, sample(), mon_exp);
            end
        end
    end

    // Reference ALU tables straight from the instruction set; -1 means unsupported
    function automatic int r_alu(logic [5:0] fn);
        case (fn)
            6'h20: return 2;  6'h22: return 6;  6'h24: return 0;  6'h25: return 1;
            6'h26: return 3;  6'h2a: return 7;  6'h02: return 5;
            default: return -1;
        endcase
    endfunction

    function automatic int i_alu(logic [5:0] op);
        case (op)
            6'h08: return 2;  6'h0a: return 7;  6'h0c: return 0;
            6'h0d: return 1;  6'h0e: return 3;  6'h0f: return 2;
            default: return -1;
        endcase
    endfunction

    function automatic bit legal(logic [5:0] op, logic [5:0] fn);
        if (op == 6'h00) return (r_alu(fn) >= 0) || fn == 6'h08 || fn == 6'h09;
        return (op inside {6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03}) || (i_alu(op) >= 0);
    endfunction

    function automatic bit rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic word_t fetch_word(bit ready);
        word_t w = '0;
        w.mrd = 1'b1; w.irw = 1'b1; w.srcb = 2'b01; w.aluop = 3'b010;
        w.pcw = WAIT_EN ? ready : 1'b1;
        return w;
    endfunction

    task automatic add(word_t w, bit mr, string t);
        seq_w.push_back(w);
        seq_mr.push_back(mr);
        seq_t.push_back({cur_name, ".", t});
    endtask

    // A memory-handshake cycle: stalls only exist when waiting is enabled
    task automatic mem_phase(word_t hold, word_t ready, int stalls, string t);
        if (WAIT_EN) begin
            for (int i = 0; i < stalls; i++) add(hold, 1'b0, {t, "_wait"});
            add(ready, 1'b1, t);
        end else begin
            add(ready, stalls == 0, t);
        end
    endtask

    // Expand one instruction into its expected cycle-by-cycle control words
    task automatic build(logic [5:0] op, logic [5:0] fn, int fst, int mst);
        word_t w;
        word_t h;
        seq_w.delete(); seq_mr.delete(); seq_t.delete();
        mem_phase(fetch_word(1'b0), fetch_word(1'b1), fst, "fetch");
        w = '0; w.srcb = 2'b11; w.aluop = 3'b010;
        if (!legal(op, fn)) begin
            w.ill = 1'b1;
            add(w, rnd_bit(), "decode_illegal");
        end else begin
            add(w, rnd_bit(), "decode");
            w = '0;
            if (op == 6'h23 || op == 6'h2b) begin
                w.srca = 1'b1; w.srcb = 2'b10; w.aluop = 3'b010;
                add(w, rnd_bit(), "mem_addr");
                h = '0; h.iord = 1'b1;
                if (op == 6'h23) begin
                    h.mrd = 1'b1;
                    mem_phase(h, h, mst, "mem_read");
                    w = '0; w.regw = 1'b1; w.m2r = 1'b1; w.done = 1'b1;
                    add(w, rnd_bit(), "mem_wb");
                end else begin
                    h.mwr = 1'b1;
                    w = h; w.done = 1'b1;
                    mem_phase(h, w, mst, "mem_write");
                end
            end else if (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)) begin
                w.pcw = 1'b1; w.pcsrc = 2'b11; w.done = 1'b1;
                if (fn == 6'h09) begin w.regw = 1'b1; w.jal = 1'b1; w.regdst = 1'b1; end
                add(w, rnd_bit(), "jr");
            end else if (op == 6'h04 || op == 6'h05) begin
                w.srca = 1'b1; w.aluop = 3'b110; w.pcwc = 1'b1; w.pcsrc = 2'b01;
                w.bne = (op == 6'h05); w.done = 1'b1;
                add(w, rnd_bit(), "branch");
            end else if (op == 6'h02 || op == 6'h03) begin
                w.pcw = 1'b1; w.pcsrc = 2'b10; w.done = 1'b1;
                w.regw = (op == 6'h03); w.jal = (op == 6'h03);
                add(w, rnd_bit(), "jump");
            end else begin
                w.srca = 1'b1;
                if (op == 6'h00) begin
                    w.aluop = 3'(r_alu(fn));
                end else begin
                    w.srcb = 2'b10; w.aluop = 3'(i_alu(op));
                    w.lui = (op == 6'h0f); w.sig = op inside {6'h0c, 6'h0d, 6'h0e};
                end
                add(w, rnd_bit(), "exec");
                w = '0; w.regw = 1'b1; w.regdst = (op == 6'h00); w.done = 1'b1;
                add(w, rnd_bit(), "alu_wb");
            end
        end
    endtask

    // Issue the first n cycles of the built sequence: push expectations, drive mem_ready
    task automatic run_seq(int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(seq_w[i]);
            tag_q.push_back(seq_t[i]);
            bus.mem_ready = seq_mr[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(string name, logic [5:0] op, logic [5:0] fn, int fst, int mst);
        cur_name = name;
        build(op, fn, fst, mst);
        bus.opcode = op;
        bus.funct  = fn;
        run_seq(seq_w.size());
    endtask

    // The RESET state occupies the cycle in which rst_n is released
    task automatic reset_cycle();
        cur_name = "post_reset";
        seq_w.delete(); seq_mr.delete(); seq_t.delete();
        add('0, rnd_bit(), "reset_state");
        run_seq(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        rst_n = 1'b1;
        bus.opcode = '0;
        bus.funct = '0;
        bus.mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_cycle();

        run_instr("lw",       6'h23, 6'h00, 0, 0);
        run_instr("add",      6'h00, 6'h20, 0, 0);
        run_instr("xori",     6'h0e, 6'h15, 0, 0);
        run_instr("bne",      6'h05, 6'h2a, 0, 0);
        run_instr("beq",      6'h04, 6'h00, 0, 0);
        run_instr("jal",      6'h03, 6'h3f, 0, 0);
        run_instr("jalr",     6'h00, 6'h09, 0, 0);
        run_instr("sw_stall", 6'h2b, 6'h00, 0, 3);
        run_instr("lw_stall", 6'h23, 6'h00, 2, 1);
        run_instr("lui",      6'h0f, 6'h00, 1, 0);
        run_instr("ill_op",   6'h3f, 6'h00, 0, 0);
        run_instr("ill_fn",   6'h00, 6'h3f, 0, 0);

        // Abandon a load in MEM_READ: outputs must clear at once, no MEM_WB afterwards
        cur_name = "lw_abort";
        build(6'h23, 6'h00, 0, 0);
        bus.opcode = 6'h23;
        bus.funct  = 6'h00;
        run_seq(3);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_cycle();
        run_instr("jr", 6'h00, 6'h08, 0, 0);

        for (int i = 0; i < 150; i++) begin
            op = ops[$urandom_range(0, 12)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            fn = 6'($urandom);
            if (op == 6'h00 && $urandom_range(0, 5) != 0) fn = fns[$urandom_range(0, 8)];
            run_instr($sformatf("rnd%0d_op%02h_fn%02h", i, op, fn), op, fn,
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        done = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Multi-cycle sequencer for the MIPS-subset CPU: a Moore FSM that steps the shared datapath (single memory, one ALU, IR/MDR/A/B/ALUOut registers) through fetch, decode, execute, memory and write-back. It replaces per-instruction combinational control with per-state control. It drives every datapath mux and write-enable, and stalls on a memory-ready handshake.

## Interface
- Parameters: none.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completed the current read/write this cycle
- PCWrite, PCWriteCond, BNE  out  1  PC load unconditional / on branch condition / invert zero test
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 register A
- IorD  out  1  memory address: 0 PC, 1 ALUOut
- MemRead, MemWrite, IRWrite  out  1  memory and IR strobes
- ALUSrcA  out  1  0 PC, 1 A
- ALUSrcB  out  2  00 B, 01 const 4, 10 imm, 11 imm<<2
- ALUop  out  3  010 add, 110 sub, 000 and, 001 or, 011 xor, 111 slt, 101 srl
- RegDst, MemtoReg, RegWrite, Jal, LUI, signal  out  1  write-back controls; Jal writes PC to $31 (jal) or rd (jalr); signal=1 zero-extends imm
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode/funct

## Operation
- States: RESET, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP, JAL, JR.
- RESET: all outputs 0. Next state is always FETCH.
- FETCH: MemRead, IRWrite, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=010, PCWrite, PCSource=00. Next state is DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=010 (branch target into ALUOut). Dispatch on opcode:
  - 23/2b go to MEM_ADDR.
  - 00 goes to JR if funct is 08/09, otherwise to EXEC_R.
  - 08/0a/0c/0d/0e/0f go to EXEC_I.
  - 04/05 go to BRANCH.
  - 02 goes to JUMP; 03 goes to JAL.
  - Any other opcode pulses illegal_op and returns to FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUop=010. Next state is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead, IorD=1. Next state is MEM_WB.
- MEM_WB: RegWrite, MemtoReg, RegDst=0, instr_done.
- MEM_WRITE: MemWrite, IorD=1, instr_done.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUop from funct.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUop from opcode. LUI=1 for 0f; signal=1 for 0c/0d/0e.
- ALU_WB: RegWrite. RegDst=1 after EXEC_R, 0 after EXEC_I. instr_done.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=110, PCWriteCond, PCSource=01, BNE=1 for opcode 05, instr_done.
- JUMP: PCWrite, PCSource=10, instr_done.
- JAL: PCWrite, PCSource=10, RegWrite, Jal, instr_done.
- JR: PCWrite, PCSource=11, instr_done. For jalr (funct 09) also RegWrite, Jal, RegDst=1.
- All final states return to FETCH.
- R-type funct mapping: 20 add, 22 sub, 24 and, 25 or, 26 xor, 2a slt, 02 srl. Any other funct pulses illegal_op in DECODE.
- Outputs are decoded from the state register only. opcode/funct are sampled in DECODE, EXEC_*, MEM_ADDR, BRANCH and JR; the datapath holds IR stable after FETCH.

## Timing
- Latency in cycles (no memory stalls): R-type 4, I-type ALU 4, lw 5, sw 4, beq/bne 3, j/jal/jr/jalr 3.
- First FETCH occurs 1 cycle after rst_n deasserts.
- Async reset forces state to RESET immediately, and every output reads 0 within the same cycle. Reset mid-instruction abandons the instruction with no partial write.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.

## Configuration
- MC_CTRL_MEM_WAIT_EN defined:
  - FETCH, MEM_READ and MEM_WRITE hold state and strobes until mem_ready=1.
  - PCWrite and instr_done in FETCH/MEM_WRITE assert only in the mem_ready cycle.
- MC_CTRL_MEM_WAIT_EN undefined:
  - mem_ready is unused and every memory state lasts exactly 1 cycle.

## Structure
- Package ctrl_pkg holds:
  - opcode and funct localparams;
  - ALUop encodings;
  - the state enum (4-bit);
  - the PCSource and ALUSrcB encodings.
- Sub-module alu_op_decode maps (state class, opcode, funct) to ALUop and an illegal flag. The FSM instantiates it once.

## Test plan
- Reset then lw (opcode 23), mem_ready tied 1 -> state sequence RESET, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB; RegWrite=MemtoReg=1 only in cycle 5; instr_done pulses once.
- add (00/20), then xori (0e) -> ALUop=010 in EXEC_R, RegDst=1 in ALU_WB; ALUop=011 with signal=1 in EXEC_I, RegDst=0.
- bne (05) -> BRANCH asserts PCWriteCond=1, BNE=1, PCSource=01, ALUop=110; returns to FETCH after 3 cycles total.
- jal (03), then jalr (00/09) -> Jal=RegWrite=PCWrite=1 with PCSource=10, then PCSource=11; both take 3 cycles.
- With MC_CTRL_MEM_WAIT_EN, sw with mem_ready low 3 cycles -> MemWrite held 4 cycles, instr_done only in the ready cycle.
- Opcode 3f, then rst_n pulsed low during MEM_READ -> illegal_op pulses in DECODE and FSM returns to FETCH; all outputs 0 immediately on reset, FETCH resumes 1 cycle after release.
